pedestrian_signal: RTL and testbench
====================================

Name: pedestrian_signal

Overview:
Pedestrian crossing controller that sits directly downstream of the vehicle traffic light. It consumes the light's registered red/yellow/green lamp outputs and a push-button request. It grants a walk phase only at the start of a red-only vehicle phase, then drives walk/stop lamps, a flashing clearance interval and a remaining-time countdown. Any vehicle yellow or green seen while pedestrians have right of way triggers a sticky safety fault.

Parameters:
WALK_TIME, 6, cycles walk_o is steadily lit (>=1)
CLEAR_TIME, 4, cycles of flashing clearance after walk (>=1)
FLASH_HALF, 1, cycles per walk_o toggle during clearance (>=1)
CNT_W, $clog2(WALK_TIME+CLEAR_TIME+1), countdown width (derived, localparam)

Ports:
clk_i  input  1  system clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-low (rst_i==0 at a rising edge resets)
car_red_i  input  1  vehicle red lamp from the traffic light
car_yellow_i  input  1  vehicle yellow lamp
car_green_i  input  1  vehicle green lamp
req_i  input  1  pedestrian request, synchronous level, any width
walk_o  output  1  walk lamp (steady in WALK, flashing in CLEAR)
stop_o  output  1  don't-walk lamp
req_pending_o  output  1  request latched, not yet served
countdown_o  output  CNT_W  remaining walk+clear cycles, 0 when not crossing
fault_o  output  1  sticky safety fault

Behaviour:
- All outputs registered. Reset values: walk_o=0, stop_o=1, req_pending_o=0, countdown_o=0, fault_o=0, state=STOP, red_only_q=0.
- red_only = car_red_i & ~car_yellow_i & ~car_green_i. red_only_q is its 1-cycle delayed copy. red_start = red_only & ~red_only_q.
- The request latch sets on any cycle with req_i=1 (req_pending_o high from the next cycle). It clears on the edge entering WALK. A request arriving while in WALK/CLEAR is latched for the next red phase. A request arriving on the same edge as STOP->WALK is absorbed, and the latch clears.
- States:
  - STOP: stop_o=1, walk_o=0. Go to WALK when red_start and (req_pending_o or req_i). A request made mid-red waits for the next red_start; there is no mid-phase start.
  - WALK: stop_o=0, walk_o=1 for exactly WALK_TIME cycles, then CLEAR.
  - CLEAR: stop_o=0 for exactly CLEAR_TIME cycles. walk_o=0 in the first CLEAR cycle and toggles every FLASH_HALF cycles. Then STOP.
  - FAULT: stop_o=1, walk_o=0, fault_o=1, countdown_o=0. Left only by reset.
- Latency: walk_o and stop_o change on the clock edge where red_start is sampled, i.e. 1 cycle after red_only first goes high.
- countdown_o = WALK_TIME+CLEAR_TIME in the first WALK cycle and decrements by 1 each cycle. It is 1 in the last CLEAR cycle and 0 in STOP.
- Safety: in WALK or CLEAR, car_yellow_i or car_green_i sampled high moves to FAULT at that edge (outputs safe on the next cycle). This includes vehicle red+yellow. A car_red_i drop alone (all lamps off) also moves to FAULT. Deasserting req_i never shortens a phase.
- Integration constraint: WALK_TIME+CLEAR_TIME must not exceed the light's red-only duration. A violation surfaces as fault_o, never as an overlapping walk/green.
- Reset mid-operation: rst_i=0 in any state returns to the reset values at that edge, including clearing fault_o and the request latch.
- Simultaneous events: a safety abort takes priority over the CLEAR->STOP transition on the same edge.

Test Plan:
- Reset, then req_i 1-cycle pulse during vehicle green -> req_pending_o=1 next cycle. When red-only begins, walk_o=1 one cycle later for 6 cycles, countdown_o 10..5, req_pending_o=0.
- Continuing that run, CLEAR with FLASH_HALF=1 -> walk_o pattern 0,1,0,1, stop_o=0, countdown_o 4..1. Then stop_o=1, walk_o=0, countdown_o=0.
- req_i asserted 2 cycles after red-only started -> no walk in that red phase. Walk starts 1 cycle after the following red-only onset.
- Force car_yellow_i=1 at WALK cycle 3 -> next cycle stop_o=1, walk_o=0, fault_o=1. fault_o stays 1 through later red phases until rst_i=0.
- rst_i=0 for 1 cycle during CLEAR -> next cycle all outputs at reset values, req_pending_o=0. No walk without a new request.
- No request over 3 full vehicle cycles -> stop_o constantly 1, walk_o 0, fault_o 0.

Source files
------------

// File: rtl/pedestrian_signal.sv
// Pedestrian crossing controller slaved to the vehicle light's lamp outputs.
// Grants walk only at red-only onset; any vehicle conflict latches a fault.
module pedestrian_signal #(
    parameter int WALK_TIME  = 6,
    parameter int CLEAR_TIME = 4,
    parameter int FLASH_HALF = 1,
    localparam int CNT_W     = $clog2(WALK_TIME + CLEAR_TIME + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             car_red_i,
    input  logic             car_yellow_i,
    input  logic             car_green_i,
    input  logic             req_i,
    output logic             walk_o,
    output logic             stop_o,
    output logic             req_pending_o,
    output logic [CNT_W-1:0] countdown_o,
    output logic             fault_o
);

    localparam int TOTAL = WALK_TIME + CLEAR_TIME;
    localparam int FL_W  = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state_q;
    logic             red_only_q;
    logic             walk_q;
    logic             stop_q;
    logic             req_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;
    logic [FL_W-1:0]  flash_q;

    logic red_only;
    logic red_start;
    logic unsafe;

    assign red_only  = car_red_i & ~car_yellow_i & ~car_green_i;
    assign red_start = red_only & ~red_only_q;
    // Anything other than a lit red (yellow, green, or red dropping out) is a conflict.
    assign unsafe    = car_yellow_i | car_green_i | ~car_red_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= STOP;
            red_only_q <= 1'b0;
            walk_q     <= 1'b0;
            stop_q     <= 1'b1;
            req_q      <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            flash_q    <= '0;
        end else begin
            red_only_q <= red_only;
            // Safety abort outranks every phase transition, including CLEAR->STOP.
            if ((state_q == WALK || state_q == CLEAR) && unsafe) begin
                state_q <= FAULT;
                walk_q  <= 1'b0;
                stop_q  <= 1'b1;
                fault_q <= 1'b1;
                cnt_q   <= '0;
                req_q   <= req_q | req_i;
            end else begin
                case (state_q)
                    STOP: begin
                        if (red_start && (req_q || req_i)) begin
                            state_q <= WALK;
                            walk_q  <= 1'b1;
                            stop_q  <= 1'b0;
                            cnt_q   <= CNT_W'(TOTAL);
                            req_q   <= 1'b0;
                        end else begin
                            req_q <= req_q | req_i;
                        end
                    end
                    WALK: begin
                        req_q <= req_q | req_i;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(CLEAR_TIME + 1)) begin
                            state_q <= CLEAR;
                            walk_q  <= 1'b0;
                            flash_q <= '0;
                        end
                    end
                    CLEAR: begin
                        req_q <= req_q | req_i;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= STOP;
                            walk_q  <= 1'b0;
                            stop_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                            if (flash_q == FL_W'(FLASH_HALF - 1)) begin
                                walk_q  <= ~walk_q;
                                flash_q <= '0;
                            end else begin
                                flash_q <= flash_q + FL_W'(1);
                            end
                        end
                    end
                    FAULT: begin
                        req_q   <= req_q | req_i;
                        walk_q  <= 1'b0;
                        stop_q  <= 1'b1;
                        fault_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                    default: begin
                        state_q <= FAULT;
                        walk_q  <= 1'b0;
                        stop_q  <= 1'b1;
                        fault_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign walk_o        = walk_q;
    assign stop_o        = stop_q;
    assign req_pending_o = req_q;
    assign countdown_o   = cnt_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_pedestrian_signal.sv
// Directed bench for pedestrian_signal with default timing (6 walk, 4 clear, flash 1).
module tb_pedestrian_signal;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic             car_red_i = 1'b0;
    logic             car_yellow_i = 1'b0;
    logic             car_green_i = 1'b1;
    logic             req_i = 1'b0;
    logic             walk_o;
    logic             stop_o;
    logic             req_pending_o;
    logic [CNT_W-1:0] countdown_o;
    logic             fault_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  got;
    logic [7:0]  exp;

    pedestrian_signal #(
        .WALK_TIME (6),
        .CLEAR_TIME(4),
        .FLASH_HALF(1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .car_red_i    (car_red_i),
        .car_yellow_i (car_yellow_i),
        .car_green_i  (car_green_i),
        .req_i        (req_i),
        .walk_o       (walk_o),
        .stop_o       (stop_o),
        .req_pending_o(req_pending_o),
        .countdown_o  (countdown_o),
        .fault_o      (fault_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs read there reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_car(input logic r, input logic y, input logic g);
        car_red_i    = r;
        car_yellow_i = y;
        car_green_i  = g;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        set_car(0, 0, 1);
        req_i = 1'b0;
        tick();
        tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL reset_values: got %b want %b", got, exp);
            n_err++;
        end
        rst_i = 1'b1;
        tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL post_reset_idle: got %b want %b", got, exp);
            n_err++;
        end
    endtask

    task automatic test_walk_clear();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL req_latch: got %b want %b", got, exp);
            n_err++;
        end
        tick();
        tick();
        set_car(0, 1, 0);
        tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL req_held_yellow: got %b want %b", got, exp);
            n_err++;
        end
        set_car(1, 0, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
            exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'(10 - i)};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL walk_cycle%0d: got %b want %b", i, got, exp);
                n_err++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
            exp = {1'(i % 2), 1'b0, 1'b0, 1'b0, 4'(4 - i)};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL clear_cycle%0d: got %b want %b", i, got, exp);
                n_err++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
            exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL back_to_stop%0d: got %b want %b", i, got, exp);
                n_err++;
            end
        end
    endtask

    task automatic test_mid_red_req();
        set_car(0, 0, 1);
        repeat (3) tick();
        set_car(0, 1, 0);
        tick();
        set_car(1, 0, 0);
        tick();
        tick();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
            exp = {1'b0, 1'b1, 1'b1, 1'b0, 4'd0};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL mid_red_wait%0d: got %b want %b", i, got, exp);
                n_err++;
            end
        end
        set_car(0, 0, 1);
        repeat (2) tick();
        set_car(0, 1, 0);
        tick();
        set_car(1, 0, 0);
        tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd10};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL next_red_walk: got %b want %b", got, exp);
            n_err++;
        end
        repeat (10) tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL mid_red_done: got %b want %b", got, exp);
            n_err++;
        end
    endtask

    task automatic test_same_edge_req();
        set_car(0, 0, 1);
        repeat (2) tick();
        set_car(0, 1, 0);
        tick();
        set_car(1, 0, 0);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd10};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL same_edge_absorb: got %b want %b", got, exp);
            n_err++;
        end
        repeat (10) tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL same_edge_done: got %b want %b", got, exp);
            n_err++;
        end
    endtask

    task automatic test_fault();
        set_car(0, 0, 1);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        set_car(0, 1, 0);
        tick();
        set_car(1, 0, 0);
        repeat (3) tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd8};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL walk_cycle3: got %b want %b", got, exp);
            n_err++;
        end
        set_car(1, 1, 0);
        tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL yellow_fault: got %b want %b", got, exp);
            n_err++;
        end
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 16; i++) begin
                if (i < 3) set_car(0, 0, 1);
                else if (i < 4) set_car(0, 1, 0);
                else set_car(1, 0, 0);
                tick();
                got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
                exp = {1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
                n_cmp++;
                if (got !== exp) begin
                    $display("FAIL fault_sticky c%0d i%0d: got %b want %b", c, i, got, exp);
                    n_err++;
                end
            end
        end
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL fault_cleared: got %b want %b", got, exp);
            n_err++;
        end
    endtask

    task automatic test_reset_in_clear();
        set_car(0, 0, 1);
        tick();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        set_car(0, 1, 0);
        tick();
        set_car(1, 0, 0);
        tick();
        repeat (6) tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b0, 1'b0, 1'b0, 4'd4};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL clear_entry: got %b want %b", got, exp);
            n_err++;
        end
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL req_in_clear: got %b want %b", got, exp);
            n_err++;
        end
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL reset_in_clear: got %b want %b", got, exp);
            n_err++;
        end
        for (int i = 0; i < 28; i++) begin
            if (i >= 12 && i < 15) set_car(0, 0, 1);
            else if (i == 15) set_car(0, 1, 0);
            else set_car(1, 0, 0);
            tick();
            got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
            n_cmp++;
            if (got !== exp) begin
                $display("FAIL no_walk_after_reset%0d: got %b want %b", i, got, exp);
                n_err++;
            end
        end
    endtask

    task automatic test_red_drop();
        set_car(0, 0, 1);
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
        set_car(0, 1, 0);
        tick();
        set_car(1, 0, 0);
        tick();
        repeat (9) tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 4'd1};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL last_clear: got %b want %b", got, exp);
            n_err++;
        end
        set_car(0, 0, 0);
        tick();
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b1, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL red_drop_fault: got %b want %b", got, exp);
            n_err++;
        end
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        n_cmp++;
        if (got !== exp) begin
            $display("FAIL red_drop_reset: got %b want %b", got, exp);
            n_err++;
        end
    endtask

    task automatic test_no_request();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 4'd0};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 18; i++) begin
                if (i < 4) set_car(0, 0, 1);
                else if (i < 6) set_car(0, 1, 0);
                else set_car(1, 0, 0);
                tick();
                got = {walk_o, stop_o, req_pending_o, fault_o, countdown_o};
                n_cmp++;
                if (got !== exp) begin
                    $display("FAIL idle c%0d i%0d: got %b want %b", c, i, got, exp);
                    n_err++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_walk_clear();
        test_mid_red_req();
        test_same_edge_req();
        test_fault();
        test_reset_in_clear();
        test_red_drop();
        test_no_request();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
